// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Execute-stage multi-cycle unit for the RV32M MUL/MULH/MULHSU/MULHU and
//   DIV/DIVU/REM/REMU operations. It latches the ID/EX operands on i_start.
//   While the operation runs it holds the upstream pipeline through
//   o_stall_req. It hands the result and rd to EX/MEM with a one-cycle o_done.
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   i_start      : ID/EX holds a valid M-op
//   i_funct3     : operation select (bit 2 = divide family)
//   i_op_a/b     : rs1/rs2 data after forwarding
//   i_rd         : destination register
//   i_flush      : kill the in-flight op (wins over i_start)
//   o_stall_req  : hold PC, IF/ID and ID/EX (combinational)
//   o_busy       : unit not idle
//   o_done       : result valid, exactly one cycle
//   o_result     : product half, quotient or remainder (held between ops)
//   o_rd         : rd of the completed op (held between ops)
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_stall_req,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_a, r_b, r_rem, r_result;
  logic [1:0]      r_op;
  logic [4:0]      r_rd, r_rd_out;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r;

  // Launch-time decode, taken straight from the ID/EX operands
  logic            w_launch, w_div_signed, w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_res;

  assign w_launch      = (r_state == S_IDLE) & i_start & ~i_flush;
  assign w_div_signed  = ~i_funct3[0];
  assign w_a_neg       = w_div_signed & i_op_a[XLEN-1];
  assign w_b_neg       = w_div_signed & i_op_b[XLEN-1];
  assign w_abs_a       = w_a_neg ? (~i_op_a + ONE) : i_op_a;
  assign w_abs_b       = w_b_neg ? (~i_op_b + ONE) : i_op_b;
  assign w_div_zero    = (i_op_b == {XLEN{1'b0}});
  assign w_div_ovf     = w_div_signed & (i_op_a == MIN_NEG) & (i_op_b == ALL_ONES);
  assign w_special     = i_funct3[2] & (w_div_zero | w_div_ovf);
  // Divide-by-zero takes precedence; the overflow case only applies to signed ops
  assign w_special_res = w_div_zero ? (i_funct3[1] ? i_op_a : ALL_ONES)
                                    : (i_funct3[1] ? {XLEN{1'b0}} : MIN_NEG);

  // Multiply: sign-extend to 2*XLEN so one unsigned multiply serves all signedness mixes
  logic              w_mul_a_sgn, w_mul_b_sgn;
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_a_sgn = (r_op == 2'b01) | (r_op == 2'b10);
  assign w_mul_b_sgn = (r_op == 2'b01);
  assign w_mul_a     = {{XLEN{w_mul_a_sgn & r_a[XLEN-1]}}, r_a};
  assign w_mul_b     = {{XLEN{w_mul_b_sgn & r_b[XLEN-1]}}, r_b};
  assign w_prod      = w_mul_a * w_mul_b;
  assign w_mul_res   = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Restoring divide step: r_a shifts dividend bits out and quotient bits in
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_div_res;

  assign w_shift    = {r_rem, r_a[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {r_a[XLEN-2:0], w_qbit};
  assign w_div_res  = r_op[1] ? (r_neg_r ? (~w_rem_next + ONE) : w_rem_next)
                              : (r_neg_q ? (~w_quo_next + ONE) : w_quo_next);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_state_next = r_state;
    o_stall_req  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall_req = w_launch;
        if (w_launch) begin
          if (!i_funct3[2]) begin
            w_state_next = S_MUL;
          end else if (w_special) begin
            w_state_next = S_FIN;
          end else begin
            w_state_next = S_DIV;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_MUL: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
        if (i_flush) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_FIN;
        end
      end
      S_DIV: begin
        o_stall_req = 1'b1;
        o_busy      = 1'b1;
        if (i_flush) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == {CW{1'b0}}) begin
          w_state_next = S_FIN;
        end else begin
          w_state_next = S_DIV;
        end
      end
      S_FIN: begin
        // start is ignored here: ID/EX still shows the op that is completing
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= {XLEN{1'b0}};
      r_b      <= {XLEN{1'b0}};
      r_rem    <= {XLEN{1'b0}};
      r_result <= {XLEN{1'b0}};
      r_op     <= 2'b00;
      r_rd     <= 5'd0;
      r_rd_out <= 5'd0;
      r_cnt    <= {CW{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_op    <= i_funct3[1:0];
            r_rd    <= i_rd;
            r_rem   <= {XLEN{1'b0}};
            r_cnt   <= CNT_LAST;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            // Divides iterate on magnitudes; multiplies keep raw operands
            r_a     <= i_funct3[2] ? w_abs_a : i_op_a;
            r_b     <= i_funct3[2] ? w_abs_b : i_op_b;
            if (w_special) begin
              r_result <= w_special_res;
              r_rd_out <= i_rd;
            end
          end
        end
        S_MUL: begin
          if (!i_flush) begin
            r_result <= w_mul_res;
            r_rd_out <= r_rd;
          end
        end
        S_DIV: begin
          r_a   <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (!i_flush && (r_cnt == {CW{1'b0}})) begin
            r_result <= w_div_res;
            r_rd_out <= r_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_rd     = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk, rst, i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_op_a, i_op_b;
  logic [4:0]  i_rd;
  logic        o_stall_req, o_busy, o_done;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_funct3(i_funct3),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_rd(i_rd), .i_flush(i_flush),
    .o_stall_req(o_stall_req), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_rd(o_rd)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model in plain 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb2 = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     pr;
    case (f)
      3'd0: begin pr = ua * ub; return pr[31:0]; end
      3'd1: begin pr = sa * sb2; return pr[63:32]; end
      3'd2: begin pr = sa * longint'(ub); return pr[63:32]; end
      3'd3: begin pr = ua * ub; return pr[63:32]; end
      3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; pr = sa / sb2; return pr[31:0]; end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; pr = ua / ub; return pr[31:0]; end
      3'd6: begin if (b == 32'd0) return a; pr = sa % sb2; return pr[31:0]; end
      default: begin if (b == 32'd0) return a; pr = ua % ub; return pr[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse pops and compares one scoreboard entry
  always @(negedge clk) begin
    if (!rst && o_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h with empty scoreboard (cycle %0d)", o_result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", o_result, e.res);
        chk("rd_out", {27'd0, o_rd}, {27'd0, e.rd});
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    i_start = 1'b1; i_funct3 = f; i_op_a = a; i_op_b = b; i_rd = rd;
  endtask

  // Issue one op, check stall/busy every cycle, and confirm done was consumed
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat, input bit hold);
    exp_t e;
    @(negedge clk);
    drive(f, a, b, rd);
    e.res = exp_res; e.rd = rd; e.due = cyc + lat;
    sb.push_back(e);
    #1;
    chk("stall_c0", {31'd0, o_stall_req}, 32'd1);
    chk("busy_c0", {31'd0, o_busy}, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) i_start = 1'b0;
      i_op_a = $urandom; i_op_b = $urandom;
      #1;
      chk("stall_run", {31'd0, o_stall_req}, (k < lat) ? 32'd1 : 32'd0);
      chk("busy_run", {31'd0, o_busy}, 32'd1);
    end
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk("idle_after", {30'd0, o_busy, o_done}, 32'd0);
    chk("done_seen", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic do_rand_op();
    logic [2:0]  f;
    logic [31:0] a, b;
    f = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: a = 32'd0;
      1: a = 32'hFFFF_FFFF;
      2: a = 32'h8000_0000;
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 6))
      0: b = 32'd0;
      1: b = 32'hFFFF_FFFF;
      2: b = 32'd1;
      3: b = 32'($urandom_range(2, 50));
      default: b = $urandom;
    endcase
    do_op(f, a, b, 5'($urandom_range(0, 31)), ref_res(f, a, b), ref_lat(f, a, b), 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_funct3 = 3'd0;
    i_op_a = 32'd0; i_op_b = 32'd0; i_rd = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {o_result[26:0], o_rd}, 32'd0);
    chk("reset_ctrl", {29'd0, o_stall_req, o_busy, o_done}, 32'd0);

    // Directed cases with hand-derived expectations
    do_op(3'd0, 32'd7, 32'hFFFF_FFF9, 5'd1, 32'hFFFF_FFCF, 2, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2, 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 2, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 2, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, 5'd9, 32'd5, 1, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1, 1'b0);

    // Flush a DIV in cycle 10, then a MUL issued in cycle 12
    @(negedge clk);
    drive(3'd4, 32'd1000, 32'd3, 5'd12);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (k == 10) i_flush = 1'b1;
    end
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, o_busy}, 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 5'd13, 32'd12, 2, 1'b0);

    // Synchronous reset in cycle 5 of a DIV
    @(negedge clk);
    drive(3'd5, 32'hDEAD_BEEF, 32'd9, 5'd14);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", o_result, 32'd0);
    chk("rst_ctrl", {24'd0, o_rd, o_stall_req, o_busy, o_done}, 32'd0);

    // start held through FIN must not relaunch
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 2, 1'b1);
    do_op(3'd7, 32'd100, 32'd7, 5'd16, 32'd2, 33, 1'b1);

    for (int n = 0; n < 40; n++) do_rand_op();

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
